uart_frame_sequencer: RTL and testbench

//  Controller in front of the 2x4-cell UART transmitter. It loads host bytes into transmitter cells
//  and plays out a masked set of cells, optionally repeated, as back-to-back frames. It owns the

---
 rtl/uart_frame_sequencer.sv | 139 +++++++++++++
 tb/tb_uart_frame_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_sequencer
// Purpose  : Loads host bytes into the 2x4-cell UART transmitter and plays out
//            a masked, optionally repeated set of cells as back-to-back frames.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_sequencer #(
  parameter int W   = 8,
  parameter int GAP = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [2:0]   wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic         start,
  input  logic [7:0]   mask,
  input  logic [3:0]   reps,
  input  logic         abort,
  output logic         busy,
  output logic         done,
  output logic [7:0]   frames_sent,
  output logic [2:0]   cur_idx,
  output logic [W-1:0] tx_d,
  output logic         tx_row,
  output logic [1:0]   tx_col,
  output logic [3:0]   tx_action,
  input  logic         tx_busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SCAN   = 3'd1,
    S_LAUNCH = 3'd2,
    S_SEND   = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] mask_q;
  logic [7:0] pending;
  logic [3:0] pass;
  logic [3:0] gap_cnt;
  logic       abort_q;
  logic [2:0] low_idx;
  logic       start_ok;
  logic       wr_go;

  always_comb begin
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pending[i]) low_idx = 3'(i);
    end
  end

  // A valid start in IDLE wins over a write arriving in the same cycle.
  assign start_ok = (state == S_IDLE) && start && (mask != 8'd0);
  assign wr_go    = !rst && (state == S_IDLE) && !start_ok && wr_valid && !tx_busy;
  assign wr_ready = wr_go;
  assign busy     = (state != S_IDLE);
  assign tx_d     = wr_go ? wr_data : '0;
  assign tx_row   = wr_go ? wr_addr[2]   : cur_idx[2];
  assign tx_col   = wr_go ? wr_addr[1:0] : cur_idx[1:0];

  // In SEND, send is only held while the transmitter is busy so it never re-triggers.
  always_comb begin
    tx_action = 4'd0;
    if (!rst) begin
      if (wr_go)                           tx_action = 4'd1;
      else if (state == S_LAUNCH)          tx_action = 4'd2;
      else if (state == S_SEND && tx_busy) tx_action = 4'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      mask_q      <= 8'd0;
      pending     <= 8'd0;
      pass        <= 4'd0;
      gap_cnt     <= 4'd0;
      abort_q     <= 1'b0;
      done        <= 1'b0;
      frames_sent <= 8'd0;
      cur_idx     <= 3'd0;
    end else begin
      done <= 1'b0;
      if (state != S_IDLE && abort) abort_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            mask_q      <= mask;
            pending     <= mask;
            pass        <= (reps == 4'd0) ? 4'd1 : reps;
            frames_sent <= 8'd0;
            abort_q     <= 1'b0;
            state       <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (abort_q || abort) begin
            pending <= 8'd0;
            pass    <= 4'd0;
            abort_q <= 1'b0;
            done    <= 1'b1;
            state   <= S_IDLE;
          end else if (pending != 8'd0) begin
            cur_idx <= low_idx;
            state   <= S_LAUNCH;
          end else if (pass > 4'd1) begin
            pass    <= pass - 4'd1;
            pending <= mask_q;
          end else begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_LAUNCH: state <= S_SEND;
        S_SEND: begin
          if (!tx_busy) begin
            pending[cur_idx] <= 1'b0;
            if (frames_sent != 8'hFF) frames_sent <= frames_sent + 8'd1;
            gap_cnt <= 4'(GAP);
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt <= 4'd1) state <= S_SCAN;
          else                 gap_cnt <= gap_cnt - 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_sequencer
// Purpose  : Directed bench for uart_frame_sequencer with a simple busy model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [2:0] wr_addr = 3'd0;
  logic [7:0] wr_data = 8'd0;
  logic       start = 1'b0;
  logic [7:0] mask = 8'd0;
  logic [3:0] reps = 4'd0;
  logic       abort = 1'b0;
  logic       busy, done;
  logic [7:0] frames_sent;
  logic [2:0] cur_idx;
  logic [7:0] tx_d;
  logic       tx_row;
  logic [1:0] tx_col;
  logic [3:0] tx_action;
  logic       tx_busy = 1'b0;
  logic [3:0] bcnt = 4'd0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int launches = 0;
  int done_cnt = 0;
  int seq[$];
  int ltime[$];

  uart_frame_sequencer #(.W(8), .GAP(1)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .start(start), .mask(mask),
    .reps(reps), .abort(abort), .busy(busy), .done(done),
    .frames_sent(frames_sent), .cur_idx(cur_idx), .tx_d(tx_d),
    .tx_row(tx_row), .tx_col(tx_col), .tx_action(tx_action), .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  // Transmitter stand-in: a send while idle makes it busy for 9 cycles.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_busy) begin
      if (bcnt == 4'd1) tx_busy <= 1'b0;
      bcnt <= bcnt - 4'd1;
    end else if (tx_action == 4'd2) begin
      tx_busy <= 1'b1;
      bcnt    <= 4'd9;
    end
  end

  always @(negedge clk) begin
    if (tx_action == 4'd2 && !tx_busy) begin
      launches = launches + 1;
      seq.push_back(int'(cur_idx));
      ltime.push_back(cyc);
    end
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    launches = 0;
    done_cnt = 0;
    seq.delete();
    ltime.delete();
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && done_cnt == 0; i++) tick(1);
    tick(3);
    check("done_pulses", done_cnt, 1);
    check("idle_after", busy, 0);
  endtask

  task automatic wait_launches(input int n);
    for (int i = 0; i < 3000 && launches < n; i++) tick(1);
    check("launch_reached", launches, n);
  endtask

  task automatic kick(input logic [7:0] m, input logic [3:0] r);
    clear_log();
    mask  = m;
    reps  = r;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    mask  = 8'h00;
    reps  = 4'd0;
  endtask

  initial begin
    // Reset
    tick(2);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_frames", frames_sent, 0);
    check("rst_idx", cur_idx, 0);
    check("rst_tx_d", tx_d, 0);
    check("rst_rowcol", {tx_row, tx_col}, 0);
    check("rst_action", tx_action, 0);
    rst = 1'b0;
    tick(1);

    // Host writes
    wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 8'hA5;
    #1;
    check("wr0_ready", wr_ready, 1);
    check("wr0_action", tx_action, 1);
    check("wr0_d", tx_d, 8'hA5);
    check("wr0_rowcol", {tx_row, tx_col}, 3'b000);
    tick(1);
    wr_addr = 3'd5; wr_data = 8'h3C;
    #1;
    check("wr5_ready", wr_ready, 1);
    check("wr5_action", tx_action, 1);
    check("wr5_d", tx_d, 8'h3C);
    check("wr5_rowcol", {tx_row, tx_col}, 3'b101);
    tick(1);
    wr_valid = 1'b0;
    #1;
    check("wr_idle_action", tx_action, 0);

    // Two-cell playout
    kick(8'h21, 4'd1);
    wait_done();
    check("p_launches", launches, 2);
    check("p_frames", frames_sent, 2);
    check("p_first", seq[0], 0);
    check("p_second", seq[1], 5);
    check("p_spacing", ltime[1] - ltime[0], 13);

    // Repeat counts
    kick(8'h80, 4'd0);
    wait_done();
    check("r0_launches", launches, 1);
    check("r0_idx", seq[0], 7);
    kick(8'h80, 4'd3);
    wait_done();
    check("r3_launches", launches, 3);
    check("r3_frames", frames_sent, 3);
    for (int i = 0; i < 3; i++) check("r3_idx", seq[i], 7);

    // Abort during the second frame
    kick(8'hFF, 4'd1);
    wait_launches(2);
    tick(3);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    wait_done();
    check("ab_launches", launches, 2);
    check("ab_frames", frames_sent, 2);

    // Empty mask start is ignored
    clear_log();
    mask = 8'h00; start = 1'b1;
    tick(1);
    start = 1'b0;
    check("m0_busy", busy, 0);
    tick(3);
    check("m0_done", done_cnt, 0);

    // Start beats a simultaneous write; write then waits while busy
    clear_log();
    start = 1'b1; mask = 8'h01; reps = 4'd1;
    wr_valid = 1'b1; wr_addr = 3'd2; wr_data = 8'h11;
    #1;
    check("ct_ready", wr_ready, 0);
    check("ct_action", tx_action, 0);
    tick(1);
    start = 1'b0;
    check("ct_busy", busy, 1);
    check("ct_ready_busy", wr_ready, 0);
    wr_valid = 1'b0;

    // Reset in the middle of a frame
    wait_launches(1);
    tick(3);
    check("mid_send_action", tx_action, 2);
    rst = 1'b1;
    tick(1);
    check("rs_busy", busy, 0);
    check("rs_action", tx_action, 0);
    check("rs_frames", frames_sent, 0);
    rst = 1'b0;
    tick(12);
    check("rs_no_done", done_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
